tanh_seq: RTL and testbench
===========================

# tanh_seq

Streaming front-end for the shared piecewise-quadratic tanh unit. Accepts fixed-point operands over a valid/ready handshake and presents each to the unit for one full 6-cycle evaluation window aligned to the unit's free-running phase. Captures the result at the window's final cycle and buffers results in a small output FIFO for the LSTM gate datapath. This block is the initiator/driver side of the tanh unit's operand/result interface.

## Interface
- QN, 6, integer bits of the signed Q format
- QM, 11, fractional bits; word width W = QN+QM+1 = 18
- FIFO_DEPTH, 4, result buffer entries; power of two, ≥2
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; must be the same reset net that drives the tanh unit
- in_data  in  W  signed operand
- in_valid  in  1  operand offered
- in_ready  out  1  operand accepted on a clock edge where in_valid && in_ready
- out_data  out  W  signed tanh result, head of FIFO
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer pops on out_valid && out_ready
- act_operand  out  W  drives the tanh unit operand input
- act_result  in  W  tanh unit result output
- busy  out  1  inflight || FIFO non-empty
- done_count  out  16  only with TANH_SEQ_COUNT_EN

## Operation
- Phase counter `phase` in 0..5: reset→0, increments each cycle, wraps 5→0. Mirrors the unit FSM (0 IDLE, 1 INTERVAL_CHOICE, 2 COEF_CHOICE, 3 MAC1, 4 MAC2, 5 END).
- Unit contract: operand stable for phases 0..5 of a window; act_result valid only during phase 5 of that window.
- Issue: in_ready = (phase==5) && (fifo_count + inflight < FIFO_DEPTH). On accept, act_operand ← in_data and inflight ← 1; act_operand held for the next six cycles.
- Capture: on the edge ending phase 5 with inflight==1, push act_result into the FIFO; inflight ← 0 unless a new accept occurs on the same edge (then it stays 1).
- Capture and accept on the same edge are normal steady state. The captured act_result belongs to the previous window.
- Credit check ignores a same-edge pop, which is conservative. The FIFO never overflows, and no push is ever dropped.
- FIFO: in-order; push and pop on the same edge leaves the count unchanged; out_data is the registered head.
- With no accept, act_operand holds its last value; the unit's output is ignored.
- Arithmetic: none in this block; data passes through bit-exact.

## Timing
- Reset values: in_ready 0, out_valid 0, out_data 0, act_operand 0, busy 0, done_count 0, phase 0, inflight 0, FIFO empty.
- First in_ready: 6th cycle after reset deasserts (phase 5).
- Throughput: one operand per 6 cycles maximum.
- Latency: accept edge → out_valid high 6 cycles later (FIFO empty, out_ready irrelevant).
- Reset mid-operation: inflight result and FIFO contents are discarded. Phase restarts at 0 together with the unit, and no stale result is ever pushed.
- in_valid may drop at any time without consequence; in_data is sampled only on the accept edge.

## Configuration
- TANH_SEQ_COUNT_EN defined: done_count is a 16-bit counter that increments on every FIFO push, wraps at 0xFFFF→0, and resets to 0.
- Not defined: the done_count port and its counter are absent; all other behaviour is identical.

## Test plan
- Bench instantiates the tanh unit with the shared clock/reset. Operand 18'h00000 accepted → out_data 18'h3FFF9 (−7 LSB, interval [0,1) p0) exactly 6 cycles after accept.
- Operands 18'h02000 (+4.0), then 18'h3E000 (−4.0) → 18'h00800 then 18'h3F800, in order, 6 cycles apart.
- in_valid held high with 8 distinct operands, out_ready=1 → in_ready pulses only at phase 5, one accept per 6 cycles, 8 results in input order, busy low 1 cycle after the last pop.
- out_ready=0, FIFO_DEPTH=4, continuous in_valid → exactly 4 accepts, then in_ready stays 0. Raising out_ready drains 4 results in order, and accepts resume at the next phase 5 with free credit.
- Reset asserted while inflight=1 and FIFO holds 2 → the cycle after reset: out_valid 0, busy 0, act_operand 0; first in_ready 6 cycles after deassert; no stale output appears.
- TANH_SEQ_COUNT_EN defined, 5 operands → done_count=5; preload the counter to 0xFFFF via force → the next push yields 0.

Source files
------------

// File: rtl/tanh_seq_if.sv
// Operand/result stream bundle for tanh_seq.
// master = producer/consumer side, slave = tanh_seq.
interface tanh_seq_if #(
  parameter int W = 18
) ();
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/tanh_seq.sv
// Streaming front-end for the shared 6-phase tanh unit, with an in-order result FIFO.
// Optional TANH_SEQ_COUNT_EN adds a 16-bit wrapping count of results pushed.
module tanh_seq #(
  parameter  int QN         = 6,
  parameter  int QM         = 11,
  parameter  int FIFO_DEPTH = 4,
  localparam int W          = QN + QM + 1
) (
  input  logic         clock,
  input  logic         reset,
  tanh_seq_if.slave    s,
  output logic [W-1:0] act_operand,
  input  logic [W-1:0] act_result,
  output logic         busy
`ifdef TANH_SEQ_COUNT_EN
  ,
  output logic [15:0]  done_count
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    PH_IDLE     = 3'd0,
    PH_INTERVAL = 3'd1,
    PH_COEF     = 3'd2,
    PH_MAC1     = 3'd3,
    PH_MAC2     = 3'd4,
    PH_END      = 3'd5
  } phase_e;

  phase_e          phase_q, phase_d;
  logic            inflight_q, inflight_d;
  logic [W-1:0]    act_operand_q, act_operand_d;
  logic [W-1:0]    mem_q [FIFO_DEPTH];
  logic [W-1:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic            busy_q, busy_d;
  logic            accept_s, push_s, pop_s;
`ifdef TANH_SEQ_COUNT_EN
  logic [15:0]     done_count_q, done_count_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q       <= PH_IDLE;
      inflight_q    <= 1'b0;
      act_operand_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      busy_q        <= 1'b0;
`ifdef TANH_SEQ_COUNT_EN
      done_count_q  <= 16'h0000;
`endif
    end else begin
      phase_q       <= phase_d;
      inflight_q    <= inflight_d;
      act_operand_q <= act_operand_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      busy_q        <= busy_d;
`ifdef TANH_SEQ_COUNT_EN
      done_count_q  <= done_count_d;
`endif
    end
  end

  always_comb begin
    phase_d       = phase_q;
    inflight_d    = inflight_q;
    act_operand_d = act_operand_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    accept_s      = 1'b0;
    push_s        = 1'b0;
    pop_s         = 1'b0;

    case (phase_q)
      PH_IDLE:     phase_d = PH_INTERVAL;
      PH_INTERVAL: phase_d = PH_COEF;
      PH_COEF:     phase_d = PH_MAC1;
      PH_MAC1:     phase_d = PH_MAC2;
      PH_MAC2:     phase_d = PH_END;
      PH_END:      phase_d = PH_IDLE;
      default:     phase_d = PH_IDLE;
    endcase

    // in_ready_q is only ever high during PH_END, so accepts land on window boundaries.
    accept_s = s.in_valid && in_ready_q;
    push_s   = (phase_q == PH_END) && inflight_q;
    pop_s    = out_valid_q && s.out_ready;

    if (accept_s) begin
      act_operand_d = s.in_data;
      inflight_d    = 1'b1;
    end else if (push_s) begin
      inflight_d    = 1'b0;
    end else begin
      inflight_d    = inflight_q;
    end

    if (push_s) begin
      mem_d[wr_ptr_q] = act_result;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_comb begin
    out_valid_d = (count_d != '0);
    busy_d      = inflight_d || (count_d != '0);
    in_ready_d  = (phase_d == PH_END) &&
                  (({1'b0, count_d} + {{CW{1'b0}}, inflight_d}) < DEPTH_L);
    if (count_d != '0) begin
      out_data_d = mem_d[rd_ptr_d];
    end else begin
      out_data_d = out_data_q;
    end
`ifdef TANH_SEQ_COUNT_EN
    if (push_s) begin
      done_count_d = done_count_q + 16'd1;
    end else begin
      done_count_d = done_count_q;
    end
`endif
  end

  assign act_operand = act_operand_q;
  assign s.in_ready  = in_ready_q;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign busy        = busy_q;
`ifdef TANH_SEQ_COUNT_EN
  assign done_count  = done_count_q;
`endif

endmodule

// File: tb/tb_tanh_seq.sv
// Self-checking bench for tanh_seq: a stand-in tanh unit plus a queue-based reference model.
module tb_tanh_seq;
  localparam int W     = 18;
  localparam int DEPTH = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] act_operand;
  logic [W-1:0] act_result;
  logic [W-1:0] garbage;
  logic         busy;
`ifdef TANH_SEQ_COUNT_EN
  logic [15:0]  done_count;
`endif

  always #5 clock = ~clock;

  tanh_seq_if #(.W(W)) bus ();

  tanh_seq #(.QN(6), .QM(11), .FIFO_DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .s           (bus.slave),
    .act_operand (act_operand),
    .act_result  (act_result),
    .busy        (busy)
`ifdef TANH_SEQ_COUNT_EN
    ,
    .done_count  (done_count)
`endif
  );

  // Stand-in tanh unit values: the documented points, otherwise an arbitrary bijection.
  function automatic logic [W-1:0] unit_f(input logic [W-1:0] x);
    case (x)
      18'h00000: return 18'h3FFF9;
      18'h02000: return 18'h00800;
      18'h3E000: return 18'h3F800;
      default:   return {x[8:0], x[17:9]} ^ 18'h2A5C3;
    endcase
  endfunction

  // Reference model state
  int           m_phase;
  bit           m_inflight;
  logic [W-1:0] m_op;
  logic [W-1:0] m_fifo[$];

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           n_acc = 0;
  int           acc_edge[$];
  logic [W-1:0] acc_val[$];
  logic [W-1:0] pop_val[$];
  int           pop_cyc[$];

  // The unit only guarantees its result in the last phase of a window.
  always_comb act_result = (m_phase == 5) ? unit_f(act_operand) : garbage;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check outputs at the negedge, then advance model and DUT by one clock.
  task automatic cycle();
    bit exp_ready, pop, push, acc;
    exp_ready = (m_phase == 5) && (m_fifo.size() + int'(m_inflight) < DEPTH);
    chk1("in_ready", bus.in_ready, exp_ready);
    chk1("out_valid", bus.out_valid, m_fifo.size() != 0);
    if (m_fifo.size() != 0) chkw("out_data", bus.out_data, m_fifo[0]);
    chk1("busy", busy, m_inflight || (m_fifo.size() != 0));
    chkw("act_operand", act_operand, m_op);
    if (bus.in_valid && bus.in_ready) begin
      n_acc++;
      acc_edge.push_back(cyc + 1);
      acc_val.push_back(bus.in_data);
    end
    if (bus.out_valid && bus.out_ready) begin
      pop_val.push_back(bus.out_data);
      pop_cyc.push_back(cyc);
    end
    pop  = (m_fifo.size() != 0) && bus.out_ready;
    push = (m_phase == 5) && m_inflight;
    acc  = bus.in_valid && exp_ready;
    @(posedge clock);
    #1;
    cyc++;
    if (reset) begin
      m_fifo.delete();
      m_inflight = 1'b0;
      m_op       = '0;
      m_phase    = 0;
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (push) m_fifo.push_back(unit_f(m_op));
      if (acc) begin
        m_op       = bus.in_data;
        m_inflight = 1'b1;
      end else if (push) begin
        m_inflight = 1'b0;
      end
      m_phase = (m_phase + 1) % 6;
    end
    garbage = W'($urandom);
    @(negedge clock);
  endtask

  // Offer d until accepted; waited = cycles spent before the accepting cycle.
  task automatic send(input logic [W-1:0] d, output int waited);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    waited = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.in_ready === 1'b1) break;
      cycle();
      waited++;
    end
    chk1("accept_timeout", bus.in_ready, 1'b1);
    cycle();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (busy === 1'b0) break;
      cycle();
    end
    chk1("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    int           waited;
    int           e0;
    logic [W-1:0] ops[8];

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    garbage       = '0;
    m_phase       = 0;
    m_inflight    = 1'b0;
    m_op          = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Reset state
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chkw("rst_out_data", bus.out_data, 18'h00000);
    chk1("rst_busy", busy, 1'b0);
    chkw("rst_act_operand", act_operand, 18'h00000);
`ifdef TANH_SEQ_COUNT_EN
    chkw("rst_done_count", {2'b00, done_count}, 18'h00000);
`endif

    // Zero operand: first ready on the 6th cycle, result 6 edges after accept
    send(18'h00000, waited);
    bus.in_valid = 1'b0;
    chki("first_ready_wait", waited, 5);
    e0 = acc_edge[acc_edge.size() - 1];
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid === 1'b1) break;
      cycle();
    end
    chk1("lat_timeout", bus.out_valid, 1'b1);
    chki("latency", cyc - e0, 6);
    chkw("zero_result", bus.out_data, 18'h3FFF9);
    bus.out_ready = 1'b1;
    cycle();

    // +4.0 then -4.0, in order, 6 cycles apart
    pop_val.delete();
    pop_cyc.delete();
    send(18'h02000, waited);
    send(18'h3E000, waited);
    bus.in_valid = 1'b0;
    wait_idle();
    chki("pm4_count", pop_val.size(), 2);
    if (pop_val.size() == 2) begin
      chkw("plus4", pop_val[0], 18'h00800);
      chkw("minus4", pop_val[1], 18'h3F800);
      chki("pm4_spacing", pop_cyc[1] - pop_cyc[0], 6);
    end

    // Continuous in_valid with 8 distinct random operands
    for (int k = 0; k < 8; k++) ops[k] = {k[2:0], 15'($urandom)};
    pop_val.delete();
    pop_cyc.delete();
    acc_edge.delete();
    for (int k = 0; k < 8; k++) send(ops[k], waited);
    bus.in_valid = 1'b0;
    wait_idle();
    chki("stream_count", pop_val.size(), 8);
    if (pop_val.size() == 8) begin
      for (int k = 0; k < 8; k++) chkw("stream_order", pop_val[k], unit_f(ops[k]));
      chki("busy_after_pop", cyc - pop_cyc[7], 1);
    end
    for (int k = 1; k < acc_edge.size(); k++) chki("accept_spacing", acc_edge[k] - acc_edge[k-1], 6);

    // Back-pressure: exactly DEPTH accepts, then drain and resume
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    n_acc = 0;
    acc_val.delete();
    pop_val.delete();
    for (int i = 0; i < 60; i++) begin
      bus.in_data = W'($urandom);
      cycle();
    end
    chki("bp_accepts", n_acc, DEPTH);
    chk1("bp_in_ready", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.in_data = W'($urandom);
      cycle();
    end
    chk1("bp_resumed", n_acc > DEPTH, 1'b1);
    if (pop_val.size() >= DEPTH && acc_val.size() >= DEPTH) begin
      for (int k = 0; k < DEPTH; k++) chkw("bp_drain", pop_val[k], unit_f(acc_val[k]));
    end else begin
      chki("bp_drain_count", pop_val.size(), DEPTH);
    end
    bus.in_valid = 1'b0;
    wait_idle();

    // Reset with one in flight and two buffered
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(W'($urandom), waited);
    bus.in_valid = 1'b0;
    chk1("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk1("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chkw("mid_rst_act_operand", act_operand, 18'h00000);
    pop_val.delete();
    bus.out_ready = 1'b1;
    send(18'h01234, waited);
    bus.in_valid = 1'b0;
    chki("rst_ready_wait", waited, 5);
    wait_idle();
    repeat (6) cycle();
    chki("rst_no_stale", pop_val.size(), 1);
    if (pop_val.size() == 1) chkw("rst_new_result", pop_val[0], unit_f(18'h01234));

`ifdef TANH_SEQ_COUNT_EN
    for (int k = 0; k < 4; k++) send(W'($urandom), waited);
    bus.in_valid = 1'b0;
    wait_idle();
    chkw("done_count5", {2'b00, done_count}, 18'h00005);
    force dut.done_count_q = 16'hFFFF;
    cycle();
    release dut.done_count_q;
    send(W'($urandom), waited);
    bus.in_valid = 1'b0;
    wait_idle();
    chkw("done_count_wrap", {2'b00, done_count}, 18'h00000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
